// File: rtl/dmem_access_unit_pkg.sv
// Shared CPU types for the data-memory stage: widths, FSM state encoding, error read value.
// Pure declarations, no logic, no latency, no backpressure.
package cpu_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;
    localparam logic [DATA_W-1:0] RDATA_ON_ERR = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } dmem_state_t;
endpackage

// File: rtl/dmem_access_unit_if.sv
// Data SRAM req/ack bus: master issues req/we/addr/wdata held until ack.
// The slave answers with a one-cycle ack that carries rdata, and may stall by withholding ack.
interface dmem_access_unit_if;
    logic                       bus_req;
    logic                       bus_we;
    logic [cpu_pkg::ADDR_W-1:0] bus_addr;
    logic [cpu_pkg::DATA_W-1:0] bus_wdata;
    logic                       bus_ack;
    logic [cpu_pkg::DATA_W-1:0] bus_rdata;

    modport master (output bus_req, bus_we, bus_addr, bus_wdata,
                    input  bus_ack, bus_rdata);
    modport slave  (input  bus_req, bus_we, bus_addr, bus_wdata,
                    output bus_ack, bus_rdata);
endinterface

// File: rtl/dmem_access_unit_timeout_ctr.sv
// 8-bit REQ-cycle counter: expire is combinational and asserts in the LIMIT-th enabled cycle after clr.
// Counting starts the cycle after clr, and there is no backpressure.
module dmem_timeout_ctr #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);
    logic [7:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      cnt <= '0;
        else if (clr)    cnt <= '0;
        else if (en)     cnt <= cnt + 8'd1;
    end

    // cnt holds the number of REQ cycles already spent, so the LIMIT-th cycle sees LIMIT-1
    assign expire = en && (cnt == 8'(LIMIT - 1));
endmodule

// File: rtl/dmem_access_unit.sv
// M-stage data-memory controller: IDLE -> REQ (until ack/timeout) -> DONE, minimum 3 cycles per access.
// Holds stallM while the bus is busy; DMEM_WBUF_EN posts stores through a one-entry write buffer.
module dmem_access_unit
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               MemWriteM,
    input  logic               MemToRegM,
    input  logic [DATA_W-1:0]  alu_resultM,
    input  logic [DATA_W-1:0]  WriteDataM,
    output logic [DATA_W-1:0]  MemReadDataM,
    output logic               stallM,
    output logic               mem_err,
    dmem_access_unit_if.master bus
);
`ifdef DMEM_WBUF_EN
    localparam bit WBUF = 1'b1;
`else
    localparam bit WBUF = 1'b0;
`endif

    dmem_state_t state;
    logic        access;
    logic        is_wr;
    logic        expire;
    logic        wbuf_busy;
    logic        stall_c;
    logic        unused_addr_hi;

    assign access         = MemWriteM | MemToRegM;
    assign is_wr          = MemWriteM;
    assign unused_addr_hi = ^alu_resultM[DATA_W-1:ADDR_W];

    generate
        if (TIMEOUT_CYC > 0) begin : g_tmo
            dmem_timeout_ctr #(.LIMIT(TIMEOUT_CYC)) u_tmo (
                .clk    (clk),
                .reset  (reset),
                .clr    ((state == IDLE) && access),
                .en     (state == REQ),
                .expire (expire)
            );
        end else begin : g_no_tmo
            assign expire = 1'b0;
        end
    endgenerate

    // A posted store lets the pipeline run; only a following access waits for the drain.
    always_comb begin
        stall_c = 1'b0;
        case (state)
            IDLE:    stall_c = access && !(WBUF && is_wr);
            REQ:     stall_c = wbuf_busy ? access : 1'b1;
            default: stall_c = 1'b0;
        endcase
    end

    assign stallM = reset && stall_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            MemReadDataM  <= '0;
            mem_err       <= 1'b0;
            wbuf_busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        bus.bus_req   <= 1'b1;
                        bus.bus_we    <= is_wr;
                        bus.bus_addr  <= alu_resultM[ADDR_W-1:0];
                        bus.bus_wdata <= WriteDataM;
                        wbuf_busy     <= WBUF && is_wr;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (bus.bus_ack || expire) begin
                        bus.bus_req <= 1'b0;
                        if (bus.bus_ack) begin
                            if (!bus.bus_we) MemReadDataM <= bus.bus_rdata;
                        end else begin
                            mem_err      <= 1'b1;
                            MemReadDataM <= RDATA_ON_ERR;
                        end
                        wbuf_busy <= 1'b0;
                        state     <= wbuf_busy ? IDLE : DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Memory-stage data-memory controller for the 16-bit 5-stage pipeline.
- Takes load/store requests from the M stage (MemWriteM, MemToRegM, alu_resultM, store data).
- Runs a req/ack handshake to a variable-latency data SRAM bus.
- Drives a pipeline-freeze stall until the access completes, then presents load data as MemReadDataM to the WB register.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 12, bus address width; taken from alu_resultM[ADDR_W-1:0].
- TIMEOUT_CYC, 255, maximum REQ-state cycles without ack before abort; 0 disables the timeout.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous active-low reset
- MemWriteM  in  1  store in M stage
- MemToRegM  in  1  load in M stage
- alu_resultM  in  DATA_W  effective address
- WriteDataM  in  DATA_W  store data
- MemReadDataM  out  DATA_W  load data to WB register
- stallM  out  1  freeze PC/F/D/E/M/W registers
- mem_err  out  1  sticky timeout flag
- bus_req  out  1  bus request
- bus_we  out  1  1 = write
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  DATA_W  bus write data
- bus_ack  in  1  one-cycle completion pulse
- bus_rdata  in  DATA_W  read data, valid with bus_ack

Behaviour:
- Interface decision: one clock (clk); reset is asynchronous and active-low.
- Reset values: state=IDLE; bus_req, bus_we, bus_addr, bus_wdata, MemReadDataM, mem_err, timeout counter all 0. stallM is forced 0 while reset is low.
- access = MemWriteM | MemToRegM. If both are high, the access is treated as a write.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If access is high: latch addr, wdata, we into the bus registers; go to REQ.
  - stallM = access (combinational).
- REQ:
  - bus_req=1; stallM=1; bus_addr, bus_wdata, bus_we held stable.
  - On bus_ack: capture bus_rdata into MemReadDataM for loads only (stores leave it unchanged); go to DONE.
- DONE:
  - stallM=0 for exactly one cycle; the pipeline advances at the end of this cycle.
  - MemReadDataM is valid during this cycle.
  - Always returns to IDLE, so the same M instruction is never re-issued.
- Latency: minimum 3 cycles from access seen in IDLE to stall release (IDLE, REQ with ack, DONE). Each extra ack wait adds one cycle.
- bus_ack while not in REQ is ignored.
- bus_req drops on the edge after ack and never rises again before passing through IDLE.
- Timeout (TIMEOUT_CYC>0):
  - Counter clears on entry to REQ and increments each REQ cycle.
  - When it reaches TIMEOUT_CYC without ack: drop bus_req, set mem_err=1, MemReadDataM=16'h0000, go to DONE.
  - mem_err clears only on reset.
- Reset asserted mid-access: everything returns to reset values immediately and the pending access is lost; bus_req drops asynchronously.
- Back-to-back accesses: each takes its own full IDLE/REQ/DONE sequence; there is no bubble beyond the IDLE cycle.

Optional Feature:
- Macro: DMEM_WBUF_EN.
- Defined: one-entry posted write buffer.
  - A store seen in IDLE with the buffer empty is latched into the buffer with stallM=0, and the pipeline proceeds.
  - The FSM drains the buffer through REQ; wbuf_busy stays set until ack or timeout.
  - Any access arriving while wbuf_busy stalls until the drain completes, then is serviced normally. Loads therefore never bypass a pending store.
  - A posted store has no DONE cycle: REQ returns directly to IDLE.
- Undefined: all stores block as described above.

Decomposition:
- Shared package cpu_pkg holds DATA_W=16, ADDR_W=12, the dmem_state_t enum (IDLE, REQ, DONE), and the default-read-on-error constant 16'h0000.
- One natural sub-module: dmem_timeout_ctr. It is an 8-bit counter with clear and enable inputs and an expire output, and is instantiated only when TIMEOUT_CYC>0.

Test Plan:
- Load, 2-cycle ack: MemToRegM=1, addr 0x034, ack on the 2nd REQ cycle with rdata 0xBEEF → stallM high for 3 cycles, MemReadDataM=0xBEEF in DONE, bus_addr=0x034, bus_we=0.
- Store, immediate ack: MemWriteM=1, addr 0x0FF, data 0x1234 → bus_we=1, bus_wdata=0x1234, stall released after 2 cycles, MemReadDataM unchanged.
- Timeout: TIMEOUT_CYC=4, load with no ack → bus_req falls after 4 REQ cycles, mem_err=1, MemReadDataM=0, pipeline released; mem_err persists for later accesses.
- Reset mid-REQ: drive reset=0 on the 2nd REQ cycle → bus_req=0 and stallM=0 asynchronously; after release, state is IDLE and no stray bus_req appears.
- Spurious ack: bus_ack pulses in IDLE with rdata 0xAAAA → no state change, MemReadDataM stays 0.
- DMEM_WBUF_EN: store to 0x010 followed by a load from 0x010 → the store causes no stall; the load stalls until the store ack, then a read is issued; the write is observed on the bus before the read.
